// File: rtl/core_pkg.sv
// Shared types and instruction field positions for the multi-cycle core.
package core_pkg;

    localparam int INSTR_W = 19;

    localparam int CLS_HI = 18;
    localparam int CLS_LO = 17;
    localparam int OP_HI  = 16;
    localparam int OP_LO  = 14;
    localparam int RD_LO  = 11;
    localparam int RS1_LO = 8;
    localparam int RS2_LO = 5;
    localparam int IMM_HI = 7;
    localparam int IMM_LO = 0;
    localparam int TGT_HI = 11;
    localparam int TGT_LO = 0;

    localparam logic [1:0] ST_FETCH  = 2'b00;
    localparam logic [1:0] ST_DECODE = 2'b01;
    localparam logic [1:0] ST_EXEC   = 2'b10;
    localparam logic [1:0] ST_WB     = 2'b11;

    typedef enum logic [1:0] {
        FETCH  = ST_FETCH,
        DECODE = ST_DECODE,
        EXEC   = ST_EXEC,
        WB     = ST_WB
    } state_t;

    typedef enum logic [1:0] {
        CLS_R   = 2'b00,
        CLS_I   = 2'b01,
        CLS_BZ  = 2'b10,
        CLS_JMP = 2'b11
    } class_t;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'b000,
        ALU_SUB  = 3'b001,
        ALU_AND  = 3'b010,
        ALU_OR   = 3'b011,
        ALU_XOR  = 3'b100,
        ALU_SLT  = 3'b101,
        ALU_PASS = 3'b110,
        ALU_NOT  = 3'b111
    } alu_op_t;

endpackage

// File: rtl/core_alu.sv
// Combinational ALU; carry is add carry-out or unsigned subtract borrow.
module core_alu
    import core_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  alu_op_t           op,
    output logic [DATA_W-1:0] result,
    output logic              zero,
    output logic              carry
);

    logic [DATA_W:0] sum;

    always_comb begin
        sum    = {1'b0, a} + {1'b0, b};
        result = '0;
        carry  = 1'b0;
        case (op)
            ALU_ADD: begin
                result = sum[DATA_W-1:0];
                carry  = sum[DATA_W];
            end
            ALU_SUB: begin
                result = a - b;
                carry  = (a < b);
            end
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_XOR:  result = a ^ b;
            ALU_SLT:  result = {{(DATA_W-1){1'b0}}, (a < b)};
            ALU_PASS: result = b;
            ALU_NOT:  result = ~a;
            default:  result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/multicycle_core.sv
// Multi-cycle core: fetch over a ready/request handshake, then decode, execute, write back.
//
//   state  | meaning
//   FETCH  | request imem at pc, latch ir when ready
//   DECODE | latch operand A (reg[rs1]) and operand B (reg[rs2] or imm)
//   EXEC   | ALU ops latch result/flags; BZ/JMP update pc and retire
//   WB     | write rd, advance pc, retire
module multicycle_core
    import core_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int PC_W   = 12,
    parameter int NREG   = 8
) (
    input  logic                clk,
    input  logic                rst,
    output logic                imem_req,
    output logic [PC_W-1:0]     imem_addr,
    input  logic                imem_ready,
    input  logic [INSTR_W-1:0]  imem_rdata,
    output logic [PC_W-1:0]     pc,
    output logic                zero_flag,
    output logic                carry_flag,
    output logic                retire
);

    localparam int RIDX_W = (NREG > 1) ? $clog2(NREG) : 1;

    state_t              state;
    logic [INSTR_W-1:0]  ir;
    logic [DATA_W-1:0]   opnd_a;
    logic [DATA_W-1:0]   opnd_b;
    logic [DATA_W-1:0]   alu_q;
    logic [DATA_W-1:0]   regs [NREG];

    class_t              cls;
    alu_op_t             op;
    logic [RIDX_W-1:0]   rd_idx;
    logic [RIDX_W-1:0]   rs1_idx;
    logic [RIDX_W-1:0]   rs2_idx;
    logic [DATA_W-1:0]   rs1_val;
    logic [DATA_W-1:0]   rs2_val;
    logic [DATA_W-1:0]   op_b;
    logic [DATA_W-1:0]   alu_result;
    logic                alu_zero;
    logic                alu_carry;
    logic [PC_W-1:0]     pc_inc;
    logic [PC_W-1:0]     bz_target;
    logic [PC_W-1:0]     jmp_target;
    logic                is_flow;

    assign cls     = class_t'(ir[CLS_HI:CLS_LO]);
    assign op      = alu_op_t'(ir[OP_HI:OP_LO]);
    assign rd_idx  = ir[RD_LO  +: RIDX_W];
    assign rs1_idx = ir[RS1_LO +: RIDX_W];
    assign rs2_idx = ir[RS2_LO +: RIDX_W];

    // Register 0 is hardwired to zero on read; its storage is never written.
    assign rs1_val = (rs1_idx == '0) ? '0 : regs[rs1_idx];
    assign rs2_val = (rs2_idx == '0) ? '0 : regs[rs2_idx];
    assign op_b    = (cls == CLS_I) ? DATA_W'(ir[IMM_HI:IMM_LO]) : rs2_val;

    assign pc_inc     = pc + PC_W'(1);
    assign bz_target  = pc_inc + PC_W'($signed(ir[IMM_HI:IMM_LO]));
    assign jmp_target = PC_W'(ir[TGT_HI:TGT_LO]);
    assign is_flow    = (cls == CLS_BZ) || (cls == CLS_JMP);

    core_alu #(.DATA_W(DATA_W)) u_alu (
        .a      (opnd_a),
        .b      (opnd_b),
        .op     (op),
        .result (alu_result),
        .zero   (alu_zero),
        .carry  (alu_carry)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= FETCH;
            pc         <= '0;
            ir         <= '0;
            opnd_a     <= '0;
            opnd_b     <= '0;
            alu_q      <= '0;
            zero_flag  <= 1'b0;
            carry_flag <= 1'b0;
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else begin
            case (state)
                FETCH: begin
                    if (imem_ready) begin
                        ir    <= imem_rdata;
                        state <= DECODE;
                    end
                end
                DECODE: begin
                    opnd_a <= rs1_val;
                    opnd_b <= op_b;
                    state  <= EXEC;
                end
                EXEC: begin
                    case (cls)
                        CLS_BZ: begin
                            pc    <= zero_flag ? bz_target : pc_inc;
                            state <= FETCH;
                        end
                        CLS_JMP: begin
                            pc    <= jmp_target;
                            state <= FETCH;
                        end
                        default: begin
                            alu_q      <= alu_result;
                            zero_flag  <= alu_zero;
                            carry_flag <= alu_carry;
                            state      <= WB;
                        end
                    endcase
                end
                WB: begin
                    if (rd_idx != '0) regs[rd_idx] <= alu_q;
                    pc    <= pc_inc;
                    state <= FETCH;
                end
                default: state <= FETCH;
            endcase
        end
    end

    assign imem_req  = (state == FETCH) && !rst;
    assign imem_addr = pc;
    assign retire    = (state == WB) || ((state == EXEC) && is_flow);

endmodule

// File: tb/tb_multicycle_core.sv
// Directed, table-driven bench for multicycle_core plus stall, wrap and reset-abort sequences.
module tb_multicycle_core;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_SLT  = 3'b101;
    localparam logic [2:0] OP_PASS = 3'b110;
    localparam logic [2:0] OP_NOT  = 3'b111;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [11:0] imem_addr;
    logic        imem_ready;
    logic [18:0] imem_rdata;
    logic [11:0] pc;
    logic        zero_flag;
    logic        carry_flag;
    logic        retire;

    logic [18:0] cur_instr;
    assign imem_rdata = cur_instr;

    int total = 0;
    int bad   = 0;

    multicycle_core #(.DATA_W(8), .PC_W(12), .NREG(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .pc         (pc),
        .zero_flag  (zero_flag),
        .carry_flag (carry_flag),
        .retire     (retire)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [18:0] instr;
        logic [11:0] pc_next;
        int          lat;
        int          ridx;
        logic [7:0]  rval;
        logic        z;
        logic        c;
    } vec_t;

    vec_t vecs [17];

    function automatic logic [18:0] enc_r(logic [2:0] op, logic [2:0] rd, logic [2:0] rs1, logic [2:0] rs2);
        return {2'b00, op, rd, rs1, rs2, 5'b00000};
    endfunction

    function automatic logic [18:0] enc_i(logic [2:0] op, logic [2:0] rd, logic [2:0] rs1, logic [7:0] imm);
        return {2'b01, op, rd, rs1, imm};
    endfunction

    function automatic logic [18:0] enc_bz(logic [7:0] imm);
        return {2'b10, 9'b0, imm};
    endfunction

    function automatic logic [18:0] enc_jmp(logic [11:0] tgt);
        return {2'b11, 5'b0, tgt};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Counts cycles from FETCH entry until retire is seen, then completes that cycle.
    task automatic run_step(output int n);
        bit got;
        n   = 0;
        got = 0;
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            if (retire === 1'b1) got = 1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int          n;
        logic [11:0] exp_pc;

        vecs[0]  = '{enc_i(OP_ADD, 3'd1, 3'd0, 8'h05), 12'h001, 4, 1, 8'h05, 1'b0, 1'b0};
        vecs[1]  = '{enc_r(OP_SUB, 3'd2, 3'd1, 3'd1), 12'h002, 4, 2, 8'h00, 1'b1, 1'b0};
        vecs[2]  = '{enc_bz(8'hFE),                    12'h001, 3, 1, 8'h05, 1'b1, 1'b0};
        vecs[3]  = '{enc_i(OP_ADD, 3'd3, 3'd0, 8'hFF), 12'h002, 4, 3, 8'hFF, 1'b0, 1'b0};
        vecs[4]  = '{enc_i(OP_ADD, 3'd0, 3'd3, 8'h01), 12'h003, 4, 0, 8'h00, 1'b1, 1'b1};
        vecs[5]  = '{enc_bz(8'h05),                    12'h009, 3, 1, 8'h05, 1'b1, 1'b1};
        vecs[6]  = '{enc_i(OP_OR,  3'd0, 3'd1, 8'h0A), 12'h00A, 4, 0, 8'h00, 1'b0, 1'b0};
        vecs[7]  = '{enc_bz(8'h05),                    12'h00B, 3, 1, 8'h05, 1'b0, 1'b0};
        vecs[8]  = '{enc_r(OP_SLT, 3'd5, 3'd2, 3'd1), 12'h00C, 4, 5, 8'h01, 1'b0, 1'b0};
        vecs[9]  = '{enc_r(OP_SUB, 3'd6, 3'd2, 3'd1), 12'h00D, 4, 6, 8'hFB, 1'b0, 1'b1};
        vecs[10] = '{enc_r(OP_XOR, 3'd7, 3'd3, 3'd1), 12'h00E, 4, 7, 8'hFA, 1'b0, 1'b0};
        vecs[11] = '{enc_r(OP_AND, 3'd5, 3'd3, 3'd1), 12'h00F, 4, 5, 8'h05, 1'b0, 1'b0};
        vecs[12] = '{enc_i(OP_PASS,3'd5, 3'd0, 8'h80), 12'h010, 4, 5, 8'h80, 1'b0, 1'b0};
        vecs[13] = '{enc_r(OP_NOT, 3'd6, 3'd1, 3'd0), 12'h011, 4, 6, 8'hFA, 1'b0, 1'b0};
        vecs[14] = '{enc_jmp(12'h020),                 12'h020, 3, 1, 8'h05, 1'b0, 1'b0};
        vecs[15] = '{enc_r(OP_SUB, 3'd7, 3'd1, 3'd1), 12'h021, 4, 7, 8'h00, 1'b1, 1'b0};
        vecs[16] = '{enc_bz(8'h80),                    12'hFA2, 3, 1, 8'h05, 1'b1, 1'b0};

        rst        = 1'b1;
        imem_ready = 1'b1;
        cur_instr  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_pc",       32'(pc),         32'h0);
        check("rst_req",      32'(imem_req),   32'h0);
        check("rst_retire",   32'(retire),     32'h0);
        check("rst_zero",     32'(zero_flag),  32'h0);
        check("rst_carry",    32'(carry_flag), 32'h0);
        @(posedge clk);
        #1;
        rst    = 1'b0;
        exp_pc = 12'h000;

        for (int i = 0; i < 17; i++) begin
            cur_instr = vecs[i].instr;
            check($sformatf("v%0d_addr", i), 32'(imem_addr), 32'(exp_pc));
            run_step(n);
            check($sformatf("v%0d_lat", i),   32'(n),                       32'(vecs[i].lat));
            check($sformatf("v%0d_pc", i),    32'(pc),                      32'(vecs[i].pc_next));
            check($sformatf("v%0d_reg", i),   32'(dut.regs[vecs[i].ridx]),  32'(vecs[i].rval));
            check($sformatf("v%0d_zero", i),  32'(zero_flag),               32'(vecs[i].z));
            check($sformatf("v%0d_carry", i), 32'(carry_flag),              32'(vecs[i].c));
            exp_pc = vecs[i].pc_next;
        end

        // Five stalled FETCH cycles with a decoy word on the bus.
        imem_ready = 1'b0;
        cur_instr  = enc_i(OP_ADD, 3'd1, 3'd0, 8'hEE);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("stall%0d_req", k),    32'(imem_req),  32'h1);
            check($sformatf("stall%0d_addr", k),   32'(imem_addr), 32'hFA2);
            check($sformatf("stall%0d_retire", k), 32'(retire),    32'h0);
            @(posedge clk);
            #1;
        end
        imem_ready = 1'b1;
        cur_instr  = enc_i(OP_ADD, 3'd1, 3'd1, 8'h01);
        run_step(n);
        check("stall_lat", 32'(n + 5),      32'd9);
        check("stall_pc",  32'(pc),         32'hFA3);
        check("stall_r1",  32'(dut.regs[1]), 32'h06);

        cur_instr = enc_jmp(12'hFFF);
        run_step(n);
        check("jmp_lat", 32'(n),  32'd3);
        check("jmp_pc",  32'(pc), 32'hFFF);
        cur_instr = enc_i(OP_ADD, 3'd2, 3'd0, 8'h33);
        run_step(n);
        check("wrap_pc", 32'(pc),          32'h000);
        check("wrap_r2", 32'(dut.regs[2]), 32'h33);
        cur_instr = enc_i(OP_ADD, 3'd4, 3'd0, 8'h01);
        run_step(n);
        check("pre_rst_pc", 32'(pc), 32'h001);

        // Abort a register write by asserting reset while it sits in EXEC.
        cur_instr = enc_i(OP_ADD, 3'd3, 3'd0, 8'h77);
        @(posedge clk);
        @(posedge clk);
        #2;
        check("exec_retire", 32'(retire), 32'h0);
        rst = 1'b1;
        #1;
        check("abort_req",    32'(imem_req), 32'h0);
        check("abort_pc",     32'(pc),       32'h000);
        check("abort_retire", 32'(retire),   32'h0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("abort_r3",     32'(dut.regs[3]), 32'h00);
        check("abort_req2",   32'(imem_req),    32'h0);
        check("abort_retire2",32'(retire),      32'h0);
        rst       = 1'b0;
        cur_instr = enc_i(OP_ADD, 3'd1, 3'd0, 8'h03);
        check("restart_addr", 32'(imem_addr), 32'h000);
        run_step(n);
        check("restart_lat", 32'(n),           32'd4);
        check("restart_pc",  32'(pc),          32'h001);
        check("restart_r1",  32'(dut.regs[1]), 32'h03);
        check("restart_r3",  32'(dut.regs[3]), 32'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
